// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: three per-producer result FIFOs feed one register-file
// write port through a round-robin grant, with a matching scoreboard-clear pulse.
module wb_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            sb_clr,
  output logic [4:0]      sb_clr_rd,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]            in_valid;
  logic [2:0][4:0]       in_rd;
  logic [2:0][XLEN-1:0]  in_data;
  logic [2:0]            ready;
  logic [2:0]            push;
  logic [2:0]            pop;
  logic [3:0]            nonempty;
  logic [3:0][4:0]       head_rd;
  logic [3:0][XLEN-1:0]  head_data;

  logic                  win_valid;
  logic [1:0]            win_idx;
  logic [1:0]            cand;
  logic [1:0]            rr_q;
  logic                  wb_en_q;
  logic [4:0]            wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;

  assign in_valid = {mdu_valid, lsu_valid, alu_valid};
  assign in_rd    = {mdu_rd, lsu_rd, alu_rd};
  assign in_data  = {mdu_data, lsu_data, alu_data};

  // Index 3 is never a requester; tying it off keeps 2-bit indexing in range.
  assign nonempty[3]  = 1'b0;
  assign head_rd[3]   = '0;
  assign head_data[3] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fifo
      logic [4:0]      rd_mem   [DEPTH];
      logic [XLEN-1:0] data_mem [DEPTH];
      logic [PW-1:0]   wptr_q;
      logic [PW-1:0]   rptr_q;
      logic [CW-1:0]   cnt_q;

      // Ready comes from the registered count only, so a full FIFO refuses even when popped.
      assign ready[gi]     = (cnt_q != CW'(DEPTH));
      assign push[gi]      = in_valid[gi] & ready[gi] & ~flush & (in_rd[gi] != 5'd0);
      assign nonempty[gi]  = (cnt_q != '0);
      assign head_rd[gi]   = rd_mem[rptr_q];
      assign head_data[gi] = data_mem[rptr_q];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          rd_mem[wptr_q]   <= in_rd[gi];
          data_mem[wptr_q] <= in_data[gi];
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else if (flush) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else begin
          if (push[gi]) wptr_q <= wptr_q + 1'b1;
          if (pop[gi])  rptr_q <= rptr_q + 1'b1;
          cnt_q <= cnt_q + CW'(push[gi]) - CW'(pop[gi]);
        end
      end
    end
  endgenerate

  assign alu_ready = ready[0];
  assign lsu_ready = ready[1];
  assign mdu_ready = ready[2];

  // Scan the three requesters starting at the round-robin pointer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_valid && nonempty[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  assign pop = win_valid ? 3'(3'b001 << win_idx) : 3'b000;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      rr_q      <= 2'd0;
    end else begin
      wb_en_q <= win_valid & ~flush;
      if (win_valid && !flush) begin
        wb_rd_q   <= head_rd[win_idx];
        wb_data_q <= head_data[win_idx];
      end
      if (flush) begin
        rr_q <= 2'd0;
      end else if (win_valid) begin
        rr_q <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      end
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign sb_clr    = wb_en_q;
  assign sb_clr_rd = wb_rd_q;
  assign busy      = (|nonempty) | wb_en_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the per-requester FIFOs and round-robin grant.
module tb_wb_port_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic flush = 1'b0;
  logic [2:0] v = 3'b000;
  logic [4:0] rdv [3];
  logic [XLEN-1:0] dv [3];

  logic alu_ready, lsu_ready, mdu_ready;
  logic wb_en, sb_clr, busy;
  logic [4:0] wb_rd, sb_clr_rd;
  logic [XLEN-1:0] wb_data;

  int checks = 0;
  int failures = 0;

  ent_t mq [3][$];
  int rr = 0;
  logic m_en = 1'b0;
  logic [4:0] m_rd = '0;
  logic [XLEN-1:0] m_data = '0;
  int seen_full = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .alu_valid(v[0]), .alu_rd(rdv[0]), .alu_data(dv[0]), .alu_ready(alu_ready),
    .lsu_valid(v[1]), .lsu_rd(rdv[1]), .lsu_data(dv[1]), .lsu_ready(lsu_ready),
    .mdu_valid(v[2]), .mdu_rd(rdv[2]), .mdu_data(dv[2]), .mdu_ready(mdu_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_clr(sb_clr), .sb_clr_rd(sb_clr_rd), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy();
    return (mq[0].size() != 0) || (mq[1].size() != 0) || (mq[2].size() != 0) || m_en;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    logic [2:0] rdy;
    int w;
    int idx;
    ent_t e;
    for (int i = 0; i < 3; i++) rdy[i] = (mq[i].size() != DEPTH);
    check("alu_ready", alu_ready, rdy[0]);
    check("lsu_ready", lsu_ready, rdy[1]);
    check("mdu_ready", mdu_ready, rdy[2]);
    w = -1;
    for (int k = 0; k < 3; k++) begin
      idx = (rr + k) % 3;
      if (w < 0 && mq[idx].size() != 0) w = idx;
    end
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr = 0;
      m_en = 1'b0;
    end else begin
      if (w >= 0) begin
        e = mq[w].pop_front();
        m_en = 1'b1;
        m_rd = e.rd;
        m_data = e.data;
        rr = (w + 1) % 3;
      end else begin
        m_en = 1'b0;
      end
      for (int i = 0; i < 3; i++)
        if (v[i] && rdy[i] && rdv[i] != 5'd0) mq[i].push_back(ent_t'{rdv[i], dv[i]});
    end
    #1;
    if (!lsu_ready) seen_full++;
    check("wb_en", wb_en, m_en);
    check("sb_clr", sb_clr, m_en);
    check("wb_rd", wb_rd, m_rd);
    check("sb_clr_rd", sb_clr_rd, m_rd);
    check("wb_data", wb_data, m_data);
    check("busy", busy, model_busy());
  endtask

  // Asynchronous reset pulse placed away from the clock edge.
  task automatic do_reset();
    #1 nrst = 1'b0;
    #1;
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_sb_clr", sb_clr, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, '0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) mq[i].delete();
    rr = 0;
    m_en = 1'b0;
    m_rd = '0;
    m_data = '0;
    #1 nrst = 1'b1;
  endtask

  task automatic offer(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    v[i] = 1'b1;
    rdv[i] = rd;
    dv[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rdv[i] = '0;
      dv[i] = '0;
    end
    #12 nrst = 1'b1;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_wb_en", wb_en, 1'b0);
    check("reset_wb_rd", wb_rd, 5'd0);

    // Single ALU result: writeback appears exactly two cycles after the offer.
    offer(0, 5'd5, 32'h0000_00AA);
    tick();
    v = 3'b000;
    check("t1_no_wb_yet", wb_en, 1'b0);
    tick();
    check("t1_wb_en", wb_en, 1'b1);
    check("t1_wb_rd", wb_rd, 5'd5);
    check("t1_wb_data", wb_data, 32'hAA);
    check("t1_sb_clr_rd", sb_clr_rd, 5'd5);
    tick();
    check("t1_wb_en_off", wb_en, 1'b0);
    check("t1_busy_off", busy, 1'b0);

    // All three offer together from reset: rd 1, 2, 3 in order.
    do_reset();
    offer(0, 5'd1, 32'h11);
    offer(1, 5'd2, 32'h22);
    offer(2, 5'd3, 32'h33);
    tick();
    v = 3'b000;
    tick();
    check("t2_first", wb_rd, 5'd1);
    tick();
    check("t2_second", wb_rd, 5'd2);
    tick();
    check("t2_third", wb_rd, 5'd3);
    tick();
    check("t2_idle", wb_en, 1'b0);

    // Everyone streams continuously so the LSU FIFO fills and back-pressures.
    seen_full = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) offer(i, 5'(c + 8 + i * 3), 32'($urandom));
      tick();
    end
    v = 3'b000;
    check("t3_lsu_full_seen", (seen_full > 0), 1'b1);
    for (int c = 0; c < 8; c++) tick();

    // rd==0 is accepted but never written back.
    do_reset();
    offer(2, 5'd0, 32'hDEAD);
    tick();
    v = 3'b000;
    check("t4_mdu_ready", mdu_ready, 1'b1);
    tick();
    check("t4_no_wb", wb_en, 1'b0);
    check("t4_busy", busy, 1'b0);

    // Load all FIFOs, then flush with offers present.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) offer(i, 5'(20 + c * 3 + i), 32'($urandom));
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    v = 3'b000;
    check("t5_wb_en", wb_en, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", {mdu_ready, lsu_ready, alu_ready}, 3'b111);
    offer(1, 5'd11, 32'hB);
    offer(0, 5'd10, 32'hA);
    tick();
    v = 3'b000;
    tick();
    check("t5_alu_first", wb_rd, 5'd10);
    tick();

    // Reset while entries are buffered: nothing comes out afterwards.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) offer(i, 5'(4 + c * 3 + i), 32'($urandom));
      tick();
    end
    v = 3'b000;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_wb", wb_en, 1'b0);
    end

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        rdv[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        dv[i] = 32'($urandom);
      end
      flush = ($urandom_range(0, 24) == 0);
      tick();
      flush = 1'b0;
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    v = 3'b000;
    for (int c = 0; c < 8; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three producers: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
- Each producer result is buffered in a small per-requester FIFO. A round-robin arbiter grants one result per cycle.
- Each grant drives a registered writeback and a matching scoreboard-clear pulse, which releases the pending bit for rd in the hazard scoreboard.
- Sits between the execute/memory stages and the register file / scoreboard.

Parameters:
XLEN, 32, data width of results and the write port
DEPTH, 2, entries per requester FIFO (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset; one clock, asynchronous, active-low
flush  in  1  pipeline kill (branch taken / exception): discard all buffered results
alu_valid  in  1  ALU result offered
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU FIFO can accept
lsu_valid  in  1  load result offered
lsu_rd  in  5  load destination register
lsu_data  in  XLEN  load result
lsu_ready  out  1  LSU FIFO can accept
mdu_valid  in  1  MDU result offered
mdu_rd  in  5  MDU destination register
mdu_data  in  XLEN  MDU result
mdu_ready  out  1  MDU FIFO can accept
wb_en  out  1  register-file write enable
wb_rd  out  5  register-file write address
wb_data  out  XLEN  register-file write data
sb_clr  out  1  scoreboard clear pulse, identical timing to wb_en
sb_clr_rd  out  5  register whose pending bit is cleared (equals wb_rd)
busy  out  1  any FIFO non-empty or wb_en high

Behaviour:
- Reset (async, nrst=0):
  - all FIFOs empty and read/write pointers 0
  - wb_en=0, sb_clr=0, wb_rd=0, sb_clr_rd=0, wb_data=0
  - round-robin pointer = ALU
  - busy=0; all *_ready=1 after reset releases
- Accept:
  - x_ready = (count_x != DEPTH), derived from registered count only.
  - A full FIFO does not accept, even if popped in the same cycle.
  - An entry enqueues at the edge where x_valid & x_ready & !flush.
  - rd==0 offers are accepted (ready honoured) but never enqueued and never produce wb_en.
- FIFO:
  - in-order per requester; pointers wrap modulo DEPTH
  - push and pop in the same cycle on a non-full, non-empty FIFO leave count unchanged
- Arbitration (combinational, on FIFO heads):
  - Candidates = non-empty FIFOs.
  - Priority order starts at the round-robin pointer: ALU -> LSU -> MDU -> ALU.
  - Winner is popped at the edge.
  - Pointer advances to the requester after the winner; it is unchanged when no candidate exists.
- Output:
  - wb_en/wb_rd/wb_data/sb_clr/sb_clr_rd are registered and load the winner at the same edge as the pop.
  - wb_en=sb_clr=1 for exactly one cycle per granted entry; 0 when no winner.
  - wb_rd/wb_data hold their last values when wb_en=0.
- Latency:
  - offer accepted at edge E0 -> eligible in the cycle after E0 -> wb_en high in the cycle after edge E1.
  - Minimum 2 cycles from valid&ready to wb_en.
  - Sustained throughput is one writeback per cycle total.
- Starvation: with all three FIFOs continuously non-empty, each requester is granted exactly once every 3 cycles.
- Flush (synchronous, sampled at the edge):
  - empties all FIFOs and drops any offer in the same cycle
  - forces wb_en=sb_clr=0 next cycle (an entry that would have been granted is discarded)
  - round-robin pointer resets to ALU
- Reset mid-operation: asynchronous clear of all state; in-flight entries are lost and no wb_en pulse is produced.
- busy = |count_alu | |count_lsu | |count_mdu | wb_en.

Test Plan:
- Single ALU result rd=5, data=0x0000_00AA at edge 0 -> wb_en=1, wb_rd=5, wb_data=0xAA, sb_clr_rd=5 in cycle 2 only; busy drops after.
- ALU, LSU and MDU all offer (rd=1/2/3) in the same cycle from reset -> writebacks ordered rd 1, 2, 3 in consecutive cycles; pointer ends at ALU.
- Hold lsu_valid with no drain forced, DEPTH=2 -> lsu_ready=0 after 2 accepts; third offer is stalled until a pop, then accepted; LSU order preserved.
- Offer rd=0 from MDU -> mdu_ready=1, no wb_en, busy stays 0.
- Load 2 entries per FIFO, assert flush for 1 cycle -> no further wb_en, all ready=1 and busy=0 next cycle; the next ALU offer wins first.
- Drop nrst while FIFOs hold entries -> outputs 0 immediately; no wb_en after release.
